data_memory_responder: RTL and testbench
========================================

Name: data_memory_responder

Overview:
- Memory-side end of the 32-bit data memory bus. Accepts one-bit read and four-bit per-byte write commands and returns data plus a single-cycle acknowledge after a fixed number of wait states.
- Holds a word-organised storage array. Byte lanes map big-endian on the bus: WriteEnable[3] drives bits 31:24, down to WriteEnable[0] driving bits 7:0.
- Used as the data memory model in simulation and as the FPGA block-RAM wrapper behind the data memory controller.

Parameters:
- ADDR_WIDTH, 10, word-address bits. Storage is 2**ADDR_WIDTH 32-bit words.
- LATENCY, 2, wait-state cycles between request acceptance and acknowledge. Legal range 0..15.

Ports:
- clock  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- Address  input  32  byte address. Word index = Address[ADDR_WIDTH+1:2]. Address[1:0] and upper bits are ignored.
- MWriteData  input  32  write data, pre-replicated by the controller onto the correct lanes.
- WriteEnable  input  4  per-byte write command. Non-zero means a write request.
- ReadEnable  input  1  read command.
- MReadData  output  32  read data, registered.
- DataMem_Ack  output  1  acknowledge, one-cycle pulse, registered.

Behaviour:
- Reset (asynchronous): state=IDLE, wait counter=0, DataMem_Ack=0, MReadData=0. Storage contents are not cleared.
- Request = ReadEnable | (WriteEnable != 0). The requester holds the command, address and data stable until it samples DataMem_Ack=1. It deasserts the command no earlier than the cycle after the ack.
- States: IDLE, WAIT, ACK, RELEASE.
- IDLE:
  - On a clock edge with request=1, capture the word index, WriteEnable, MWriteData and the read flag.
  - Go to WAIT with counter=LATENCY-1, or go directly to ACK if LATENCY=0.
- WAIT: decrement the counter each cycle. When the counter equals 0, go to ACK. Inputs are ignored in WAIT; the captured values are used.
- ACK (exactly one cycle):
  - DataMem_Ack=1.
  - Write: each byte i with captured WriteEnable[i]=1 is written into the storage word on the edge that leaves ACK. Other bytes are unchanged.
  - Read: MReadData already holds the addressed word. The storage read is performed on entry to ACK, so data is valid during the ack cycle.
  - Go to RELEASE.
- RELEASE: DataMem_Ack=0. Stay until request=0, then go to IDLE. A request held across the ack never starts a second access.
- Latency: ack is asserted in cycle N+1+LATENCY, where cycle N is the cycle in which the request is first seen in IDLE. The shortest back-to-back period is LATENCY+3 cycles.
- MReadData holds its value from one read ack until the next read's ACK cycle. Writes do not change MReadData.
- Simultaneous ReadEnable=1 and WriteEnable!=0: the write is performed, the read is ignored, MReadData is unchanged, and one ack is issued.
- Read-after-write to the same word in consecutive accesses returns the newly written bytes. There is no stale bypass hazard, because the write commits on the ACK-exit edge before the next capture.
- Word index wrap: address bits above ADDR_WIDTH+1 alias. For example, with ADDR_WIDTH=10, addresses 0x0000_0010 and 0x0000_1010 hit the same word.
- Reset asserted mid-access (WAIT or ACK): return to IDLE immediately and drop the ack. The pending write is discarded, because no write occurs unless the ACK-exit edge is a normal clock edge with reset low.
- Request dropped early during WAIT (protocol violation): the access still completes using the captured values. The FSM passes through RELEASE directly to IDLE.

Test Plan:
- Read, LATENCY=2:
  - Stimulus: preload word 5 = 0xDEADBEEF; assert ReadEnable with Address=0x14 in cycle 0; hold until ack.
  - Required: DataMem_Ack=1 only in cycle 3, with MReadData=0xDEADBEEF; ack=0 in cycle 4.
- Byte write:
  - Stimulus: word 2 = 0x11223344; WriteEnable=4'b0100, MWriteData=0xAAAAAAAA, Address=0x08; then read 0x08.
  - Required: read returns 0x11AA3344.
- Held request:
  - Stimulus: keep ReadEnable=1 for 6 cycles after the ack.
  - Required: exactly one ack pulse. A new ack arrives LATENCY+1 cycles after ReadEnable falls and rises again.
- LATENCY=0 back-to-back:
  - Stimulus: write 0xCAFEF00D (WriteEnable=4'b1111) to 0x40, drop the command, then read 0x40.
  - Required: each ack arrives the cycle after acceptance; the read returns 0xCAFEF00D.
- Reset mid-write:
  - Stimulus: word 7 = 0x0; start WriteEnable=4'b1111, data 0x12345678, Address=0x1C; pulse reset during WAIT; then read 0x1C.
  - Required: DataMem_Ack=0 and MReadData=0 immediately on reset; the read returns 0x00000000.
- Simultaneous read and write plus alias:
  - Stimulus: ReadEnable=1, WriteEnable=4'b0011, data 0x0000BEEF, Address=0x1004 (ADDR_WIDTH=10); then read 0x0004.
  - Required: first access acks once with MReadData unchanged; the read returns 0x????BEEF, with the upper bytes equal to their prior value.

Source files
------------

// File: rtl/data_memory_responder.sv
// Memory-side responder for the 32-bit data memory bus.
// Captures a read or byte-masked write request, waits a fixed number of
// wait states, then returns a one-cycle acknowledge with registered read data.
module data_memory_responder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] MWriteData,
  input  logic [3:0]  WriteEnable,
  input  logic        ReadEnable,
  output logic [31:0] MReadData,
  output logic        DataMem_Ack
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned LANES   = DATA_W / 8;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned DEPTH   = 2 ** ADDR_WIDTH;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'((LATENCY == 0) ? 0 : LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    ACK     = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t                  state, next_state;
  logic [CNT_W-1:0]        cnt, cnt_next;
  logic                    capture_c;
  logic                    request_c;
  logic [ADDR_WIDTH-1:0]   addr_idx_c;
  logic [ADDR_WIDTH-1:0]   cap_idx;
  logic [LANES-1:0]        cap_we;
  logic [DATA_W-1:0]       cap_data;
  logic                    cap_read;
  logic [ADDR_WIDTH-1:0]   rd_idx_c;
  logic                    rd_only_c;
  logic                    read_fire_c;
  logic [DATA_W-1:0]       mem [DEPTH];
  logic                    unused_addr_bits;

  assign request_c  = ReadEnable | (|WriteEnable);
  assign addr_idx_c = Address[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^{Address[31:ADDR_WIDTH+2], Address[1:0]};

  // Read source: live inputs on the accept edge (zero-latency path), captured values otherwise
  assign rd_idx_c    = capture_c ? addr_idx_c : cap_idx;
  assign rd_only_c   = capture_c ? (ReadEnable & ~(|WriteEnable)) : cap_read;
  assign read_fire_c = (next_state == ACK) && (state != ACK) && rd_only_c;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
    end
  end

  // Next-state and wait-counter logic
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    capture_c  = 1'b0;
    case (state)
      IDLE: begin
        if (request_c) begin
          capture_c = 1'b1;
          if (LATENCY == 0) begin
            next_state = ACK;
          end else begin
            next_state = WAIT;
            cnt_next   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) next_state = ACK;
        else           cnt_next   = cnt - CNT_W'(1);
      end
      ACK:     next_state = RELEASE;
      RELEASE: if (!request_c) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request capture; a simultaneous read and write is treated as a write only
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cap_idx  <= '0;
      cap_we   <= '0;
      cap_data <= '0;
      cap_read <= 1'b0;
    end else if (capture_c) begin
      cap_idx  <= addr_idx_c;
      cap_we   <= WriteEnable;
      cap_data <= MWriteData;
      cap_read <= ReadEnable & ~(|WriteEnable);
    end
  end

  // Registered acknowledge and read data, both valid in the ACK cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      DataMem_Ack <= 1'b0;
      MReadData   <= '0;
    end else begin
      DataMem_Ack <= (next_state == ACK) && (state != ACK);
      if (read_fire_c) MReadData <= mem[rd_idx_c];
    end
  end

  // Byte-lane write commits on the edge leaving ACK; storage is never cleared
  always_ff @(posedge clock) begin
    if (!reset && state == ACK) begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (cap_we[i]) mem[cap_idx][i*8 +: 8] <= cap_data[i*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: one instance with LATENCY=2
// (index 0) and one with LATENCY=0 (index 1), driven independently.
module tb_data_memory_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic [3:0]  we    [2];
  logic        re    [2];
  logic        ack   [2];

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  data_memory_responder #(.ADDR_WIDTH(10), .LATENCY(2)) u_dut_l2 (
    .clock      (clock),
    .reset      (reset),
    .Address    (addr[0]),
    .MWriteData (wdata[0]),
    .WriteEnable(we[0]),
    .ReadEnable (re[0]),
    .MReadData  (rdata[0]),
    .DataMem_Ack(ack[0])
  );

  data_memory_responder #(.ADDR_WIDTH(10), .LATENCY(0)) u_dut_l0 (
    .clock      (clock),
    .reset      (reset),
    .Address    (addr[1]),
    .MWriteData (wdata[1]),
    .WriteEnable(we[1]),
    .ReadEnable (re[1]),
    .MReadData  (rdata[1]),
    .DataMem_Ack(ack[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One complete bus access; call and return #1 after a rising edge with the FSM idle
  task automatic access(input int d, input string tag, input logic [3:0] w, input logic r,
                        input logic [31:0] a, input logic [31:0] wd, input int exp_lat,
                        output logic [31:0] rd);
    int lat;
    lat = 0;
    addr[d] = a; wdata[d] = wd; we[d] = w; re[d] = r;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock); #1;
      if (ack[d]) begin
        lat = k;
        break;
      end
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    rd = rdata[d];
    @(posedge clock); #1;
    check({tag, "_ackdrop"}, 32'(ack[d]), 32'd0);
    we[d] = 4'h0; re[d] = 1'b0;
    @(posedge clock); #1;
  endtask

  initial begin
    logic [31:0] rd;
    int n;
    int lat;
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      addr[d] = '0; wdata[d] = '0; we[d] = '0; re[d] = 1'b0;
    end
    @(posedge clock); @(posedge clock); #1;
    check("rst_ack_l2", 32'(ack[0]), 32'd0);
    check("rst_rd_l2",  rdata[0], 32'h0);
    check("rst_ack_l0", 32'(ack[1]), 32'd0);
    check("rst_rd_l0",  rdata[1], 32'h0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Read with two wait states
    access(0, "pre5", 4'hF, 1'b0, 32'h14, 32'hDEADBEEF, 3, rd);
    access(0, "rd5", 4'h0, 1'b1, 32'h14, 32'h0, 3, rd);
    check("rd5_data", rd, 32'hDEADBEEF);

    // Single byte-lane write
    access(0, "pre2", 4'hF, 1'b0, 32'h08, 32'h11223344, 3, rd);
    access(0, "bw2", 4'b0100, 1'b0, 32'h08, 32'hAAAAAAAA, 3, rd);
    check("bw2_rdhold", rd, 32'hDEADBEEF);
    access(0, "rd2", 4'h0, 1'b1, 32'h08, 32'h0, 3, rd);
    check("rd2_data", rd, 32'h11AA3344);

    // Request held six cycles past the ack yields a single pulse
    addr[0] = 32'h14; re[0] = 1'b1;
    n = 0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clock); #1;
      if (ack[0]) n++;
    end
    check("held_acks", 32'(n), 32'd1);
    re[0] = 1'b0;
    @(posedge clock); #1;
    re[0] = 1'b1;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock); #1;
      if (ack[0]) begin
        lat = k;
        break;
      end
    end
    check("rearm_lat", 32'(lat), 32'd3);
    check("rearm_data", rdata[0], 32'hDEADBEEF);
    @(posedge clock); #1;
    re[0] = 1'b0;
    @(posedge clock); #1;

    // Zero wait states, back to back
    access(1, "l0_wr", 4'hF, 1'b0, 32'h40, 32'hCAFEF00D, 1, rd);
    access(1, "l0_rd", 4'h0, 1'b1, 32'h40, 32'h0, 1, rd);
    check("l0_data", rd, 32'hCAFEF00D);

    // Reset during WAIT discards the pending write
    access(0, "pre7", 4'hF, 1'b0, 32'h1C, 32'h0, 3, rd);
    access(0, "rd5b", 4'h0, 1'b1, 32'h14, 32'h0, 3, rd);
    check("rd5b_data", rd, 32'hDEADBEEF);
    addr[0] = 32'h1C; wdata[0] = 32'h12345678; we[0] = 4'hF;
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    check("midrst_ack", 32'(ack[0]), 32'd0);
    check("midrst_rd", rdata[0], 32'h0);
    we[0] = 4'h0;
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    access(0, "rd7", 4'h0, 1'b1, 32'h1C, 32'h0, 3, rd);
    check("rd7_data", rd, 32'h0);

    // Simultaneous read+write through an aliased address
    access(0, "pre1", 4'hF, 1'b0, 32'h04, 32'h55667788, 3, rd);
    access(0, "rd1a", 4'h0, 1'b1, 32'h04, 32'h0, 3, rd);
    check("rd1a_data", rd, 32'h55667788);
    access(0, "rw", 4'b0011, 1'b1, 32'h1004, 32'h0000BEEF, 3, rd);
    check("rw_rdhold", rd, 32'h55667788);
    access(0, "rd1b", 4'h0, 1'b1, 32'h04, 32'h0, 3, rd);
    check("rd1b_data", rd, 32'h5566BEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
